// File: rtl/ctrl_seq_pkg.sv
// Shared types for the ctrl_seq sequencer: FSM states, opcode constants,
// instruction classification and two-phase (EXEC2) classification.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        OC_ALU, OC_LDA, OC_STA, OC_JMP, OC_JCX, OC_MUL, OC_PSH,
        OC_POP, OC_LDR, OC_STR, OC_CLL, OC_RTN, OC_NOP, OC_STP
    } op_class_e;

    localparam logic [5:0] OP_JMP = 6'b000000;
    localparam logic [5:0] OP_JMA = 6'b000001;
    localparam logic [5:0] OP_MUL = 6'b011100;
    localparam logic [5:0] OP_MLA = 6'b011101;
    localparam logic [5:0] OP_MLS = 6'b011110;
    localparam logic [5:0] OP_PSH = 6'b101000;
    localparam logic [5:0] OP_POP = 6'b101001;
    localparam logic [5:0] OP_LDR = 6'b101010;
    localparam logic [5:0] OP_STR = 6'b101011;
    localparam logic [5:0] OP_CLL = 6'b100110;
    localparam logic [5:0] OP_RTN = 6'b100111;
    localparam logic [5:0] OP_NOP = 6'b111110;
    localparam logic [5:0] OP_STP = 6'b111111;

    function automatic op_class_e classify(input logic [15:0] ir);
        logic [5:0] op;
        op = ir[14:9];
        if (ir[15]) return ir[14] ? OC_STA : OC_LDA;
        case (op)
            OP_JMP, OP_JMA:         return OC_JMP;
            OP_MUL, OP_MLA, OP_MLS: return OC_MUL;
            OP_PSH:                 return OC_PSH;
            OP_POP:                 return OC_POP;
            OP_LDR:                 return OC_LDR;
            OP_STR:                 return OC_STR;
            OP_CLL:                 return OC_CLL;
            OP_RTN:                 return OC_RTN;
            OP_NOP:                 return OC_NOP;
            OP_STP:                 return OC_STP;
            default:
                // 0001xx and 0010xx are conditional jumps; everything left is ALU
                return (op[5:2] == 4'b0001 || op[5:2] == 4'b0010) ? OC_JCX : OC_ALU;
        endcase
    endfunction

    function automatic logic is_two_phase(input op_class_e c);
        return c inside {OC_LDA, OC_LDR, OC_POP, OC_RTN, OC_MUL};
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational decode of the captured instruction register into an
// instruction class, two-phase flag and register-field selects.
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
(
    input  logic [15:0] ir,
    output op_class_e   cls,
    output logic        two_phase,
    output logic [2:0]  dst,
    output logic [2:0]  src1,
    output logic [2:0]  src2
);

    always_comb begin
        cls       = classify(ir);
        two_phase = is_two_phase(cls);
        dst       = (cls == OC_LDA) ? ir[13:11] : ir[8:6];
        src1      = ir[5:3];
        src2      = ir[2:0];
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: HALT/FETCH/EXEC1/EXEC2/FAULT with stack tracking.
// Define CTRL_SEQ_MEM_WAIT_EN to stall FETCH and final EXEC2 on mem_ready.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned MUL_CYCLES  = 1,
    parameter int unsigned NREG        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     instr,
    input  logic            cond_result,
    input  logic            mem_ready,
    output logic [2:0]      phase,
    output logic [NREG-1:0] reg_we,
    output logic [2:0]      s1,
    output logic [2:0]      s2,
    output logic [2:0]      s3,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            imem_en,
    output logic            dmem_en,
    output logic            dmem_we,
    output logic            stk_push,
    output logic            stk_pop,
    output logic            halted,
    output logic            fault
);

    localparam int unsigned OCC_W = $clog2(STACK_DEPTH) + 1;

    state_e           state;
    logic [15:0]      ir;
    logic [OCC_W-1:0] occ;
    logic [1:0]       mul_cnt;

    op_class_e cls;
    logic      two_phase;
    logic [2:0] dst, src1, src2;

    ctrl_seq_decode u_decode (
        .ir        (ir),
        .cls       (cls),
        .two_phase (two_phase),
        .dst       (dst),
        .src1      (src1),
        .src2      (src2)
    );

    logic mem_ok;
`ifdef CTRL_SEQ_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    logic stk_err, last_x2;
    logic [NREG-1:0] dst_oh;

    assign stk_err = ((cls == OC_PSH || cls == OC_CLL) && occ == OCC_W'(STACK_DEPTH))
                  || ((cls == OC_POP || cls == OC_RTN) && occ == '0);
    assign last_x2 = (mul_cnt == '0) && mem_ok;

    always_comb begin
        dst_oh = '0;
        for (int unsigned i = 0; i < NREG; i++) dst_oh[i] = (32'(dst) == i);
    end

    always_comb begin
        phase    = '0;
        reg_we   = '0;
        s1       = '0;
        s2       = '0;
        s3       = '0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        imem_en  = 1'b0;
        dmem_en  = 1'b0;
        dmem_we  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        halted   = (state == S_HALT);
        fault    = (state == S_FAULT);
        case (state)
            S_FETCH: begin
                phase   = 3'b001;
                imem_en = 1'b1;
            end
            S_EXEC1: begin
                phase = 3'b010;
                s1 = src1;
                s2 = src2;
                s3 = dst;
                // a stack overflow/underflow suppresses every strobe of the instruction
                if (!stk_err) begin
                    case (cls)
                        OC_ALU: begin reg_we = dst_oh; pc_inc = 1'b1; end
                        OC_LDA, OC_LDR: dmem_en = 1'b1;
                        OC_STA, OC_STR: begin dmem_en = 1'b1; dmem_we = 1'b1; pc_inc = 1'b1; end
                        OC_JMP: begin pc_load = 1'b1; reg_we = NREG'(1); end
                        OC_CLL: begin pc_load = 1'b1; reg_we = NREG'(1); stk_push = 1'b1; end
                        OC_JCX: begin
                            if (cond_result) begin pc_load = 1'b1; reg_we = NREG'(1); end
                            else pc_inc = 1'b1;
                        end
                        OC_PSH: begin stk_push = 1'b1; pc_inc = 1'b1; end
                        OC_POP, OC_RTN: stk_pop = 1'b1;
                        OC_NOP, OC_STP: pc_inc = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_EXEC2: begin
                phase = 3'b100;
                s1 = src1;
                s2 = src2;
                s3 = dst;
                if (last_x2) begin
                    if (cls == OC_RTN) begin
                        pc_load = 1'b1;
                        reg_we  = NREG'(1);
                    end else begin
                        reg_we = dst_oh;
                        pc_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_HALT;
            ir      <= '0;
            occ     <= '0;
            mul_cnt <= '0;
        end else begin
            case (state)
                S_HALT: if (start) state <= S_FETCH;
                S_FAULT: begin
                    if (start) begin
                        occ   <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ok) begin
                        ir    <= instr;
                        state <= S_EXEC1;
                    end
                end
                S_EXEC1: begin
                    if (stk_err) begin
                        state <= S_FAULT;
                    end else begin
                        if (stk_push) occ <= occ + 1'b1;
                        if (stk_pop)  occ <= occ - 1'b1;
                        if (cls == OC_STP) begin
                            occ   <= '0;
                            state <= S_HALT;
                        end else if (two_phase) begin
                            mul_cnt <= (cls == OC_MUL) ? 2'(MUL_CYCLES - 1) : 2'd0;
                            state   <= S_EXEC2;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_EXEC2: begin
                    if (mul_cnt != '0) mul_cnt <= mul_cnt - 1'b1;
                    else if (mem_ok)   state   <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: a per-instruction trace model predicts
// every cycle's outputs, and a negedge compare process checks the DUT.
module tb_ctrl_seq;

    localparam int DEPTH = 2;
    localparam int MULC  = 3;
    localparam int M_HALT = 0, M_RUN = 1, M_FAULT = 2;
    localparam int K_ALU = 0, K_LDA = 1, K_STA = 2, K_JMP = 3, K_JCX = 4, K_MUL = 5, K_PSH = 6;
    localparam int K_POP = 7, K_LDR = 8, K_STR = 9, K_CLL = 10, K_RTN = 11, K_NOP = 12, K_STP = 13;
    localparam logic [15:0] GARBAGE = 16'h7E00;

    typedef struct packed {
        logic [2:0] phase;
        logic [7:0] reg_we;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [2:0] s3;
        logic pc_inc, pc_load, imem_en, dmem_en, dmem_we, stk_push, stk_pop, halted, fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, cond_result, mem_ready;
    logic [15:0] instr;
    logic [2:0] phase, s1, s2, s3;
    logic [7:0] reg_we;
    logic pc_inc, pc_load, imem_en, dmem_en, dmem_we, stk_push, stk_pop, halted, fault;

    ctrl_seq #(.STACK_DEPTH(DEPTH), .MUL_CYCLES(MULC), .NREG(8)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .cond_result(cond_result),
        .mem_ready(mem_ready), .phase(phase), .reg_we(reg_we), .s1(s1), .s2(s2), .s3(s3),
        .pc_inc(pc_inc), .pc_load(pc_load), .imem_en(imem_en), .dmem_en(dmem_en),
        .dmem_we(dmem_we), .stk_push(stk_push), .stk_pop(stk_pop), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    vec_t act;
    assign act = {phase, reg_we, s1, s2, s3, pc_inc, pc_load, imem_en, dmem_en, dmem_we,
                  stk_push, stk_pop, halted, fault};

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    mode   = M_HALT;
    int    occ_m  = 0;
    vec_t  rv;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, a, e, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [5:0] op, input int rd, input int a, input int b);
        return {1'b0, op, 3'(rd), 3'(a), 3'(b)};
    endfunction

    function automatic int kind_of(input logic [15:0] w);
        logic [5:0] op;
        op = w[14:9];
        if (w[15]) return w[14] ? K_STA : K_LDA;
        if (op == 6'd0 || op == 6'd1) return K_JMP;
        if (op[5:2] == 4'd1 || op[5:2] == 4'd2) return K_JCX;
        if (op >= 6'b011100 && op <= 6'b011110) return K_MUL;
        case (op)
            6'b101000: return K_PSH;
            6'b101001: return K_POP;
            6'b101010: return K_LDR;
            6'b101011: return K_STR;
            6'b100110: return K_CLL;
            6'b100111: return K_RTN;
            6'b111110: return K_NOP;
            6'b111111: return K_STP;
            default:   return K_ALU;
        endcase
    endfunction

    task automatic put(input vec_t v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    // Expected per-cycle trace for one instruction, starting at its FETCH.
    task automatic gen(input logic [15:0] w, input logic c, input int fstall);
        vec_t v, sel;
        int k, n;
        bit err, pushes, pops;
        k = kind_of(w);
        pushes = (k == K_PSH || k == K_CLL);
        pops   = (k == K_POP || k == K_RTN);
        sel = '0;
        sel.s1 = w[5:3];
        sel.s2 = w[2:0];
        sel.s3 = (k == K_LDA) ? w[13:11] : w[8:6];
        for (int i = 0; i <= fstall; i++) begin
            v = '0; v.phase = 3'b001; v.imem_en = 1'b1;
            put(v, $sformatf("fetch_%04h", w));
        end
        err = (pushes && occ_m == DEPTH) || (pops && occ_m == 0);
        v = sel; v.phase = 3'b010;
        if (!err) begin
            case (k)
                K_ALU: begin v.reg_we = 8'(1) << sel.s3; v.pc_inc = 1'b1; end
                K_LDA, K_LDR: v.dmem_en = 1'b1;
                K_STA, K_STR: begin v.dmem_en = 1'b1; v.dmem_we = 1'b1; v.pc_inc = 1'b1; end
                K_JMP: begin v.pc_load = 1'b1; v.reg_we = 8'h01; end
                K_CLL: begin v.pc_load = 1'b1; v.reg_we = 8'h01; v.stk_push = 1'b1; end
                K_JCX: begin
                    if (c) begin v.pc_load = 1'b1; v.reg_we = 8'h01; end
                    else v.pc_inc = 1'b1;
                end
                K_PSH: begin v.stk_push = 1'b1; v.pc_inc = 1'b1; end
                K_POP, K_RTN: v.stk_pop = 1'b1;
                K_NOP, K_STP: v.pc_inc = 1'b1;
                default: ;
            endcase
        end
        put(v, $sformatf("exec1_%04h", w));
        if (err) begin mode = M_FAULT; return; end
        occ_m = occ_m + (pushes ? 1 : 0) - (pops ? 1 : 0);
        if (k == K_STP) begin mode = M_HALT; occ_m = 0; return; end
        if (k == K_LDA || k == K_LDR || k == K_POP || k == K_RTN || k == K_MUL) begin
            n = (k == K_MUL) ? MULC : 1;
            for (int i = 0; i < n; i++) begin
                v = sel; v.phase = 3'b100;
                if (i == n - 1) begin
                    if (k == K_RTN) begin v.pc_load = 1'b1; v.reg_we = 8'h01; end
                    else begin v.reg_we = 8'(1) << sel.s3; v.pc_inc = 1'b1; end
                end
                put(v, $sformatf("exec2_%0d_%04h", i, w));
            end
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (exp_q.size() != 0 && budget < 64);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 at %0t", exp_q.size(), $time);
            exp_q.delete();
            tag_q.delete();
        end
        #1;
    endtask

    task automatic issue(input logic [15:0] w, input logic c);
        instr = w;
        cond_result = c;
        gen(w, c, 0);
    endtask

    // Live instr is scrambled after capture; decode must use the held word.
    task automatic retire();
        @(posedge clk);
        #1 instr = GARBAGE;
        wait_drain();
    endtask

    task automatic do_instr(input logic [15:0] w, input logic c);
        issue(w, c);
        retire();
    endtask

    task automatic push_idle(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = '0;
            if (mode == M_HALT) v.halted = 1'b1; else v.fault = 1'b1;
            put(v, (mode == M_HALT) ? "idle_halt" : "idle_fault");
        end
        wait_drain();
    endtask

    task automatic do_start();
        vec_t v;
        v = '0;
        if (mode == M_HALT) v.halted = 1'b1; else v.fault = 1'b1;
        put(v, "start_cycle");
        if (mode == M_FAULT) occ_m = 0;
        mode  = M_RUN;
        start = 1'b1;
        wait_drain();
        start = 1'b0;
    endtask

    always @(negedge clk) begin : cmp
        vec_t  e;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, 32'(act), 32'(e));
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; instr = '0; cond_result = 1'b0; mem_ready = 1'b1;
        rv = '0; rv.halted = 1'b1;
        #3;
        chk("reset_state", 32'(act), 32'(rv));
        start = 1'b1;
        @(posedge clk);
        #1 chk("start_during_reset", 32'(act), 32'(rv));
        start = 1'b0;
        rst = 1'b0;
        mode = M_HALT; occ_m = 0;

        push_idle(3);
        do_start();

        issue(mk(6'b010000, 3, 1, 2), 1'b0);
        chk("pin_alu_len", 32'(exp_q.size()), 32'd2);
        chk("pin_alu_fetch_phase", 32'(exp_q[0].phase), 32'b001);
        chk("pin_alu_we", 32'(exp_q[1].reg_we), 32'h08);
        chk("pin_alu_inc", 32'(exp_q[1].pc_inc), 32'd1);
        retire();

        do_instr(16'hD234, 1'b0);
        do_instr(16'hA83A, 1'b0);
        issue(mk(6'b011100, 2, 4, 5), 1'b0);
        chk("pin_mul_len", 32'(exp_q.size()), 32'd5);
        chk("pin_mul_we_mid", 32'(exp_q[3].reg_we), 32'h00);
        chk("pin_mul_inc_mid", 32'(exp_q[3].pc_inc), 32'd0);
        chk("pin_mul_we_last", 32'(exp_q[4].reg_we), 32'h04);
        chk("pin_mul_inc_last", 32'(exp_q[4].pc_inc), 32'd1);
        retire();
        do_instr(mk(6'b011101, 7, 0, 1), 1'b0);
        do_instr(mk(6'b011110, 1, 3, 3), 1'b1);

        issue(mk(6'b000110, 0, 2, 3), 1'b0);
        chk("pin_jcx0_inc", 32'(exp_q[1].pc_inc), 32'd1);
        chk("pin_jcx0_load", 32'(exp_q[1].pc_load), 32'd0);
        retire();
        issue(mk(6'b001001, 5, 6, 7), 1'b1);
        chk("pin_jcx1_load", 32'(exp_q[1].pc_load), 32'd1);
        chk("pin_jcx1_we", 32'(exp_q[1].reg_we), 32'h01);
        retire();
        do_instr(mk(6'b000011, 0, 1, 1), 1'b1);
        do_instr(mk(6'b001100, 6, 2, 2), 1'b1);
        do_instr(mk(6'b000000, 4, 4, 4), 1'b0);
        do_instr(mk(6'b000001, 2, 0, 7), 1'b0);
        do_instr(mk(6'b101011, 1, 2, 3), 1'b0);
        do_instr(mk(6'b101010, 6, 1, 1), 1'b0);
        start = 1'b1;
        do_instr(mk(6'b111110, 0, 0, 0), 1'b0);
        start = 1'b0;

        do_instr(mk(6'b101000, 0, 3, 0), 1'b0);
        do_instr(mk(6'b101001, 1, 0, 0), 1'b0);
        do_instr(mk(6'b100110, 0, 0, 0), 1'b0);
        do_instr(mk(6'b100111, 0, 0, 0), 1'b0);
        do_instr(mk(6'b101001, 5, 0, 0), 1'b0);
        push_idle(2);
        do_start();

        do_instr(mk(6'b100110, 0, 0, 0), 1'b0);
        do_instr(mk(6'b100110, 0, 0, 0), 1'b0);
        issue(mk(6'b101000, 0, 1, 0), 1'b0);
        chk("pin_full_push", 32'(exp_q[1].stk_push), 32'd0);
        chk("pin_full_mode", 32'(mode), 32'(M_FAULT));
        retire();
        push_idle(2);
        do_start();
        chk("pin_fault_occ", 32'(occ_m), 32'd0);
        do_instr(mk(6'b101000, 0, 1, 0), 1'b0);
        do_instr(mk(6'b101000, 0, 2, 0), 1'b0);
        do_instr(mk(6'b111111, 0, 0, 0), 1'b0);
        push_idle(2);
        do_start();

`ifdef CTRL_SEQ_MEM_WAIT_EN
        mem_ready = 1'b0;
        instr = GARBAGE;
        cond_result = 1'b0;
        gen(mk(6'b010000, 3, 1, 2), 1'b0, 4);
        repeat (4) @(posedge clk);
        #1 mem_ready = 1'b1;
        instr = mk(6'b010000, 3, 1, 2);
        retire();
`endif

        do_instr(mk(6'b010101, 4, 5, 6), 1'b0);

        instr = 16'hA83A;
        cond_result = 1'b0;
        @(posedge clk);
        #1 instr = GARBAGE;
        @(posedge clk);
        #1 chk("lda_exec2_phase", 32'(phase), 32'b100);
        chk("lda_exec2_we", 32'(reg_we), 32'h20);
        rst = 1'b1;
        #1 chk("async_reset_mid_exec2", 32'(act), 32'(rv));
        @(posedge clk);
        #1 rst = 1'b0;
        mode = M_HALT; occ_m = 0;

        push_idle(2);
        do_start();
        do_instr(mk(6'b110000, 7, 3, 1), 1'b0);
        do_instr(mk(6'b111111, 0, 0, 0), 1'b0);
        push_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
